// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral device bus window.
// Each granted transaction runs IDLE -> XFER -> RESP; out-of-window accesses are answered with err.
module dev_bus_arbiter #(
    parameter logic [31:0] ADDR_LO = 32'h00007f00,
    parameter logic [31:0] ADDR_HI = 32'h00007f2f
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    input  logic        m0_we_i,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    input  logic        m1_we_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rd_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rd_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wd_o,
    output logic        dev_we_o,
    input  logic [31:0] dev_rd_i,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] dev_addr_q, dev_addr_d;
    logic [31:0] dev_wd_q, dev_wd_d;
    logic        we_q, we_d;
    logic        dev_we_q, dev_we_d;
    logic        oow_q, oow_d;
    logic [31:0] m0_rd_q, m0_rd_d;
    logic [31:0] m1_rd_q, m1_rd_d;

    logic        grant_m1;
    logic [31:0] win_addr;
    logic [31:0] win_wd;
    logic        win_we;
    logic        win_in_window;

    function automatic logic in_window(input logic [31:0] addr);
        return (addr >= ADDR_LO) && (addr <= ADDR_HI);
    endfunction

    // On a tie the master that did not win last time gets the bus.
    assign grant_m1      = m1_req_i && (!m0_req_i || !last_grant_q);
    assign win_addr      = grant_m1 ? m1_addr_i : m0_addr_i;
    assign win_wd        = grant_m1 ? m1_wd_i   : m0_wd_i;
    assign win_we        = grant_m1 ? m1_we_i   : m0_we_i;
    assign win_in_window = in_window(win_addr);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        dev_addr_d   = dev_addr_q;
        dev_wd_d     = dev_wd_q;
        we_d         = we_q;
        dev_we_d     = 1'b0;
        oow_d        = oow_q;
        m0_rd_d      = m0_rd_q;
        m1_rd_d      = m1_rd_q;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_d      = XFER;
                    owner_d      = grant_m1;
                    last_grant_d = grant_m1;
                    dev_addr_d   = win_addr;
                    dev_wd_d     = win_wd;
                    we_d         = win_we;
                    oow_d        = !win_in_window;
                    dev_we_d     = win_we && win_in_window;
                end
            end
            XFER: begin
                state_d = RESP;
                if (owner_q) begin
                    m1_rd_d = (we_q || oow_q) ? 32'h0 : dev_rd_i;
                end else begin
                    m0_rd_d = (we_q || oow_q) ? 32'h0 : dev_rd_i;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            dev_addr_q   <= 32'h0;
            dev_wd_q     <= 32'h0;
            we_q         <= 1'b0;
            dev_we_q     <= 1'b0;
            oow_q        <= 1'b0;
            m0_rd_q      <= 32'h0;
            m1_rd_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            dev_addr_q   <= dev_addr_d;
            dev_wd_q     <= dev_wd_d;
            we_q         <= we_d;
            dev_we_q     <= dev_we_d;
            oow_q        <= oow_d;
            m0_rd_q      <= m0_rd_d;
            m1_rd_q      <= m1_rd_d;
        end
    end

    assign m0_ack_o   = (state_q == RESP) && !owner_q;
    assign m1_ack_o   = (state_q == RESP) &&  owner_q;
    assign m0_err_o   = m0_ack_o && oow_q;
    assign m1_err_o   = m1_ack_o && oow_q;
    assign m0_rd_o    = m0_rd_q;
    assign m1_rd_o    = m1_rd_q;
    assign dev_addr_o = dev_addr_q;
    assign dev_wd_o   = dev_wd_q;
    assign dev_we_o   = dev_we_q;
    assign owner_o    = owner_q;

endmodule
